// File: rtl/tle_ksched.sv
// rtl/tle_ksched.sv - K-step scheduler: issues operand tiles, selects C source, routes D to feedback or output
module tle_ksched #(
  parameter int KCNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [KCNT_W-1:0] cmd_ktiles_i,
  input  logic              cmd_bias_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  output logic              eng_valid_o,
  input  logic              eng_ready_i,
  output logic [1:0]        c_sel_o,
  input  logic              eng_valid_i,
  output logic              eng_ready_o,
  output logic              fb_we_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [KCNT_W-1:0] tile_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [KCNT_W-1:0] ONE = KCNT_W'(1);

  state_t            state_q, state_d;
  logic [KCNT_W-1:0] remaining_q;
  logic [KCNT_W-1:0] tile_idx_q;
  logic              first_q;
  logic              bias_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        c_sel_q;
  logic              last_step;

  // remaining counts steps not yet issued, so zero in WAIT means the final D is in flight
  assign last_step  = (remaining_q == '0);
  assign tile_idx_o = tile_idx_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    op_ready_o  = 1'b0;
    eng_valid_o = 1'b0;
    c_sel_o     = 2'd0;
    eng_ready_o = 1'b0;
    fb_we_o     = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        eng_ready_o = 1'b1;
        if (cmd_valid_i && (cmd_ktiles_i != '0)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        eng_valid_o = op_valid_i;
        op_ready_o  = eng_ready_i;
        c_sel_o     = first_q ? {1'b0, bias_q} : 2'd2;
        if (op_valid_i && eng_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        c_sel_o = c_sel_q;
        if (!last_step) begin
          eng_ready_o = 1'b1;
          fb_we_o     = eng_valid_i;
          if (eng_valid_i) state_d = S_ISSUE;
        end else begin
          res_valid_o = eng_valid_i;
          eng_ready_o = res_ready_i;
          if (eng_valid_i && res_ready_i) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      tile_idx_q  <= '0;
      first_q     <= 1'b0;
      bias_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      c_sel_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_ktiles_i == '0) begin
              err_q <= 1'b1;
            end else begin
              remaining_q <= cmd_ktiles_i;
              first_q     <= 1'b1;
              bias_q      <= cmd_bias_i;
              tile_idx_q  <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (op_valid_i && eng_ready_i) begin
            remaining_q <= remaining_q - ONE;
            first_q     <= 1'b0;
            c_sel_q     <= c_sel_o;
          end
        end
        S_WAIT: begin
          if (!last_step && eng_valid_i) tile_idx_q <= tile_idx_q + ONE;
          if (last_step && eng_valid_i && res_ready_i) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tle_ksched.sv
// tb/tb_tle_ksched.sv - bench for tle_ksched with engine model and per-job step model
module tb_tle_ksched;
  localparam int KW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          cmd_valid_i = 1'b0, cmd_bias_i = 1'b0;
  logic [KW-1:0] cmd_ktiles_i = '0;
  logic          op_valid_i = 1'b0, eng_ready_i = 1'b1, eng_valid_i = 1'b0, res_ready_i = 1'b1;
  logic          cmd_ready_o, op_ready_o, eng_valid_o, eng_ready_o, fb_we_o, res_valid_o;
  logic          busy_o, done_o, err_o;
  logic [1:0]    c_sel_o;
  logic [KW-1:0] tile_idx_o;

  tle_ksched #(.KCNT_W(KW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_ktiles_i(cmd_ktiles_i), .cmd_bias_i(cmd_bias_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i),
    .c_sel_o(c_sel_o), .eng_valid_i(eng_valid_i), .eng_ready_o(eng_ready_o), .fb_we_o(fb_we_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .tile_idx_o(tile_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, lat = 3, ecnt = 0, last_csel = 0;
  bit last_in_fire = 0, last_res_fire = 0;
  int eng_csel[$], eng_tidx[$], eng_cyc[$], res_cyc[$], done_cyc[$], cmd_cyc[$];
  int fb_cnt = 0, res_cnt = 0, done_cnt = 0, err_cnt = 0, cmd_cnt = 0, busy_cnt = 0;
  int hold_cnt = 0, drain_cnt = 0, viol_nop = 0, viol_idle = 0, viol_hold = 0;

  // engine model: returns D lat cycles after input fire; monitor samples 1ns after the falling edge
  always @(negedge clk_i) begin
    if (last_res_fire) eng_valid_i = 1'b0;
    if (last_in_fire) ecnt = lat;
    if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) eng_valid_i = 1'b1;
    end
    #1;
    cyc++;
    last_in_fire  = eng_valid_o && eng_ready_i;
    last_res_fire = eng_valid_i && eng_ready_o;
    if (last_in_fire) begin
      eng_csel.push_back(int'(c_sel_o));
      eng_tidx.push_back(int'(tile_idx_o));
      eng_cyc.push_back(cyc);
      last_csel = int'(c_sel_o);
    end
    if (last_res_fire) drain_cnt++;
    if (fb_we_o) fb_cnt++;
    if (res_valid_o && res_ready_i) begin res_cnt++; res_cyc.push_back(cyc); end
    if (res_valid_o && !res_ready_i) hold_cnt++;
    if (done_o) begin done_cnt++; done_cyc.push_back(cyc); end
    if (err_o) err_cnt++;
    if (busy_o) busy_cnt++;
    if (cmd_valid_i && cmd_ready_o) begin cmd_cnt++; cmd_cyc.push_back(cyc); end
    if (eng_valid_o && !op_valid_i) viol_nop++;
    if (eng_valid_o && !busy_o) viol_idle++;
    if (res_valid_o && !res_ready_i && eng_ready_o) viol_hold++;
    if (res_valid_o && (int'(c_sel_o) != last_csel)) viol_hold++;
  end

  function automatic int exp_csel(input int step, input bit bias);
    return (step == 0) ? int'(bias) : 2;
  endfunction

  task automatic run_job(input int k, input bit b, input int stall_step, input int stall_len,
                         input int res_stall, input bit rnd, output bit ok);
    int base_e, base_r, base_c, tmo;
    base_e = eng_csel.size(); base_r = res_cnt; base_c = cmd_cnt; tmo = 0;
    cmd_ktiles_i = KW'(k); cmd_bias_i = b; cmd_valid_i = 1'b1;
    op_valid_i = 1'b1; eng_ready_i = 1'b1; res_ready_i = (res_stall == 0);
    while (res_cnt == base_r && tmo < 2000) begin
      @(posedge clk_i); #1; tmo++;
      if (cmd_cnt != base_c) cmd_valid_i = 1'b0;
      if (rnd) begin
        op_valid_i  = ($urandom_range(0, 3) != 0);
        eng_ready_i = ($urandom_range(0, 3) != 0);
        res_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        op_valid_i = !((eng_csel.size() - base_e == stall_step) && stall_len > 0);
        if (!op_valid_i) stall_len--;
        if (res_valid_o && res_stall > 0) res_stall--;
        res_ready_i = !((eng_csel.size() - base_e == k) && res_stall > 0);
      end
    end
    ok = (res_cnt != base_r);
    cmd_valid_i = 1'b0; op_valid_i = 1'b1; eng_ready_i = 1'b1; res_ready_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready_o); end
    n_cmp++; if (eng_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_eng_ready got %b want 1", eng_ready_o); end
    n_cmp++; if ({op_ready_o, eng_valid_o, fb_we_o, res_valid_o, busy_o, done_o, err_o} !== 7'b0)
      begin n_fail++; $display("FAIL reset_outs got %b want 0000000", {op_ready_o, eng_valid_o, fb_we_o, res_valid_o, busy_o, done_o, err_o}); end
    n_cmp++; if (c_sel_o !== 2'd0) begin n_fail++; $display("FAIL reset_c_sel got %0d want 0", c_sel_o); end
    n_cmp++; if (tile_idx_o !== '0) begin n_fail++; $display("FAIL reset_tile_idx got %0d want 0", tile_idx_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single();
    int be, bf, br, bd; bit ok;
    be = eng_csel.size(); bf = fb_cnt; br = res_cnt; bd = done_cnt; lat = 3;
    run_job(1, 1'b1, -1, 0, 0, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout got no result want 1"); end
    n_cmp++; if (eng_csel.size() - be !== 1) begin n_fail++; $display("FAIL single_issues got %0d want 1", eng_csel.size() - be); end
    if (eng_csel.size() - be == 1) begin
      n_cmp++; if (eng_csel[be] !== 1) begin n_fail++; $display("FAIL single_c_sel got %0d want 1", eng_csel[be]); end
    end
    n_cmp++; if (fb_cnt - bf !== 0) begin n_fail++; $display("FAIL single_fb_we got %0d want 0", fb_cnt - bf); end
    n_cmp++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL single_done got %0d want 1", done_cnt - bd); end
    if (ok && eng_csel.size() > be && done_cyc.size() > bd) begin
      n_cmp++; if (res_cyc[br] - eng_cyc[be] !== 3) begin n_fail++; $display("FAIL single_latency got %0d want 3", res_cyc[br] - eng_cyc[be]); end
      n_cmp++; if (done_cyc[bd] !== res_cyc[br] + 1) begin n_fail++; $display("FAIL single_done_time got %0d want %0d", done_cyc[bd], res_cyc[br] + 1); end
    end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", busy_o); end
  endtask

  task automatic test_multi();
    int be, bf, br; bit ok;
    be = eng_csel.size(); bf = fb_cnt; br = res_cnt; lat = 2;
    run_job(4, 1'b0, -1, 0, 0, 1'b0, ok);
    n_cmp++; if (eng_csel.size() - be !== 4) begin n_fail++; $display("FAIL multi_issues got %0d want 4", eng_csel.size() - be); end
    for (int i = 0; i < 4 && be + i < eng_csel.size(); i++) begin
      n_cmp++; if (eng_csel[be+i] !== exp_csel(i, 1'b0)) begin n_fail++; $display("FAIL multi_c_sel[%0d] got %0d want %0d", i, eng_csel[be+i], exp_csel(i, 1'b0)); end
      n_cmp++; if (eng_tidx[be+i] !== i) begin n_fail++; $display("FAIL multi_tile_idx[%0d] got %0d want %0d", i, eng_tidx[be+i], i); end
    end
    n_cmp++; if (fb_cnt - bf !== 3) begin n_fail++; $display("FAIL multi_fb_we got %0d want 3", fb_cnt - bf); end
    n_cmp++; if (res_cnt - br !== 1) begin n_fail++; $display("FAIL multi_res got %0d want 1", res_cnt - br); end
  endtask

  task automatic test_stall();
    int be, bf, bd, bh, bn, bv; bit ok;
    be = eng_csel.size(); bf = fb_cnt; bd = done_cnt; bh = hold_cnt; bn = viol_nop; bv = viol_hold; lat = 3;
    run_job(3, 1'b1, 1, 5, 4, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got no result want 1"); end
    n_cmp++; if (eng_csel.size() - be !== 3) begin n_fail++; $display("FAIL stall_issues got %0d want 3", eng_csel.size() - be); end
    for (int i = 0; i < 3 && be + i < eng_csel.size(); i++) begin
      n_cmp++; if (eng_csel[be+i] !== exp_csel(i, 1'b1)) begin n_fail++; $display("FAIL stall_c_sel[%0d] got %0d want %0d", i, eng_csel[be+i], exp_csel(i, 1'b1)); end
    end
    n_cmp++; if (viol_nop - bn !== 0) begin n_fail++; $display("FAIL stall_eng_valid_no_op got %0d want 0", viol_nop - bn); end
    n_cmp++; if (viol_hold - bv !== 0) begin n_fail++; $display("FAIL stall_backpressure got %0d want 0", viol_hold - bv); end
    n_cmp++; if (hold_cnt - bh !== 4) begin n_fail++; $display("FAIL stall_hold_cycles got %0d want 4", hold_cnt - bh); end
    n_cmp++; if (fb_cnt - bf !== 2) begin n_fail++; $display("FAIL stall_fb_we got %0d want 2", fb_cnt - bf); end
    n_cmp++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL stall_done got %0d want 1", done_cnt - bd); end
  endtask

  task automatic test_zero();
    int be, berr, bb, bc, tmo; bit ok;
    be = eng_csel.size(); berr = err_cnt; bb = busy_cnt; bc = cmd_cnt; tmo = 0;
    cmd_ktiles_i = '0; cmd_valid_i = 1'b1;
    while (cmd_cnt == bc && tmo < 20) begin @(posedge clk_i); #1; tmo++; end
    cmd_valid_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    n_cmp++; if (err_cnt - berr !== 1) begin n_fail++; $display("FAIL zero_err_pulses got %0d want 1", err_cnt - berr); end
    n_cmp++; if (busy_cnt - bb !== 0) begin n_fail++; $display("FAIL zero_busy got %0d want 0", busy_cnt - bb); end
    n_cmp++; if (eng_csel.size() - be !== 0) begin n_fail++; $display("FAIL zero_issues got %0d want 0", eng_csel.size() - be); end
    run_job(2, 1'b1, -1, 0, 0, 1'b0, ok);
    n_cmp++; if (!ok || eng_csel.size() - be !== 2) begin n_fail++; $display("FAIL zero_followup_issues got %0d want 2", eng_csel.size() - be); end
  endtask

  task automatic test_reset_mid();
    int be, bc, bf, br, bdr, tmo; bit ok;
    be = eng_csel.size(); bc = cmd_cnt; tmo = 0; lat = 5;
    cmd_ktiles_i = KW'(5); cmd_bias_i = 1'b1; cmd_valid_i = 1'b1;
    op_valid_i = 1'b1; eng_ready_i = 1'b1; res_ready_i = 1'b1;
    while (eng_csel.size() - be < 3 && tmo < 500) begin
      @(posedge clk_i); #1; tmo++;
      if (cmd_cnt != bc) cmd_valid_i = 1'b0;
    end
    n_cmp++; if (eng_csel.size() - be !== 3) begin n_fail++; $display("FAIL rmid_issues got %0d want 3", eng_csel.size() - be); end
    rst_ni = 1'b0; cmd_valid_i = 1'b0;
    #1;
    n_cmp++; if ({busy_o, cmd_ready_o, eng_ready_o} !== 3'b011) begin n_fail++; $display("FAIL rmid_async got %b want 011", {busy_o, cmd_ready_o, eng_ready_o}); end
    n_cmp++; if (tile_idx_o !== '0) begin n_fail++; $display("FAIL rmid_tile_idx got %0d want 0", tile_idx_o); end
    bf = fb_cnt; br = res_cnt; bdr = drain_cnt;
    repeat (2) begin @(posedge clk_i); #1; end
    rst_ni = 1'b1;
    repeat (6) begin @(posedge clk_i); #1; end
    n_cmp++; if (drain_cnt - bdr !== 1) begin n_fail++; $display("FAIL rmid_drained got %0d want 1", drain_cnt - bdr); end
    n_cmp++; if (fb_cnt - bf !== 0 || res_cnt - br !== 0) begin n_fail++; $display("FAIL rmid_leak got fb %0d res %0d want 0 0", fb_cnt - bf, res_cnt - br); end
    lat = 3; be = eng_csel.size(); bf = fb_cnt;
    run_job(1, 1'b1, -1, 0, 0, 1'b0, ok);
    n_cmp++; if (!ok || eng_csel.size() - be !== 1) begin n_fail++; $display("FAIL rmid_next_issues got %0d want 1", eng_csel.size() - be); end
    else begin n_cmp++; if (eng_csel[be] !== 1) begin n_fail++; $display("FAIL rmid_next_c_sel got %0d want 1", eng_csel[be]); end end
    n_cmp++; if (fb_cnt - bf !== 0) begin n_fail++; $display("FAIL rmid_next_fb_we got %0d want 0", fb_cnt - bf); end
  endtask

  task automatic test_back_to_back();
    int bc, br, bd, tmo;
    bc = cmd_cnt; br = res_cnt; bd = done_cnt; tmo = 0; lat = 2;
    cmd_ktiles_i = KW'(2); cmd_bias_i = 1'b0; cmd_valid_i = 1'b1;
    op_valid_i = 1'b1; eng_ready_i = 1'b1; res_ready_i = 1'b1;
    while (res_cnt - br < 2 && tmo < 500) begin
      @(posedge clk_i); #1; tmo++;
      if (cmd_cnt - bc >= 2) cmd_valid_i = 1'b0;
    end
    cmd_valid_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    n_cmp++; if (res_cnt - br !== 2) begin n_fail++; $display("FAIL b2b_res got %0d want 2", res_cnt - br); end
    n_cmp++; if (done_cnt - bd !== 2) begin n_fail++; $display("FAIL b2b_done got %0d want 2", done_cnt - bd); end
    n_cmp++; if (cmd_cnt - bc !== 2) begin n_fail++; $display("FAIL b2b_cmds got %0d want 2", cmd_cnt - bc); end
    else if (res_cnt - br >= 1) begin
      n_cmp++; if (cmd_cyc[bc+1] !== res_cyc[br] + 1) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", cmd_cyc[bc+1], res_cyc[br] + 1); end
    end
  endtask

  task automatic test_random();
    int k, be, bf, br, bd, bi, bv; bit b, ok;
    bi = viol_idle; bv = viol_hold;
    for (int j = 0; j < 8; j++) begin
      k = (j == 0) ? 15 : int'($urandom_range(1, 15));
      b = 1'($urandom_range(0, 1));
      lat = int'($urandom_range(1, 4));
      be = eng_csel.size(); bf = fb_cnt; br = res_cnt; bd = done_cnt;
      run_job(k, b, -1, 0, 0, 1'b1, ok);
      n_cmp++; if (!ok || eng_csel.size() - be !== k) begin n_fail++; $display("FAIL rnd%0d_issues got %0d want %0d", j, eng_csel.size() - be, k); end
      for (int i = 0; i < k && be + i < eng_csel.size(); i++) begin
        n_cmp++; if (eng_csel[be+i] !== exp_csel(i, b)) begin n_fail++; $display("FAIL rnd%0d_c_sel[%0d] got %0d want %0d", j, i, eng_csel[be+i], exp_csel(i, b)); end
        n_cmp++; if (eng_tidx[be+i] !== i) begin n_fail++; $display("FAIL rnd%0d_tile_idx[%0d] got %0d want %0d", j, i, eng_tidx[be+i], i); end
      end
      n_cmp++; if (fb_cnt - bf !== k - 1) begin n_fail++; $display("FAIL rnd%0d_fb_we got %0d want %0d", j, fb_cnt - bf, k - 1); end
      n_cmp++; if (res_cnt - br !== 1 || done_cnt - bd !== 1) begin n_fail++; $display("FAIL rnd%0d_res_done got %0d/%0d want 1/1", j, res_cnt - br, done_cnt - bd); end
    end
    n_cmp++; if (viol_idle - bi !== 0) begin n_fail++; $display("FAIL rnd_eng_valid_idle got %0d want 0", viol_idle - bi); end
    n_cmp++; if (viol_hold - bv !== 0) begin n_fail++; $display("FAIL rnd_backpressure got %0d want 0", viol_hold - bv); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tle_ksched.md
Name: tle_ksched

Overview:
- K-dimension scheduler for the tile-level matmul engine (D = A*B + C over one MxNxK tile).
- Accepts a job command of ktiles K-steps and gates the upstream A/B operand-tile stream into the engine input handshake.
- Selects the engine's C source per step: zero, external bias, or the feedback register holding the previous D.
- Captures intermediate D into the feedback register; forwards only the final D downstream.
- Control-only: the datapath muxes and the feedback register live outside; this block drives their selects and enables.

Parameters:
KCNT_W, 16, width of K-tile count and index.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  job command valid
cmd_ready_o  out  1  job command accepted (high only in IDLE)
cmd_ktiles_i  in  KCNT_W  number of K-steps in job, unsigned
cmd_bias_i  in  1  1: first step uses external C; 0: first step uses zero
op_valid_i  in  1  upstream A/B tile valid
op_ready_o  out  1  upstream A/B tile consumed
eng_valid_o  out  1  engine input valid
eng_ready_i  in  1  engine input ready
c_sel_o  out  2  C mux select: 0 zero, 1 bias, 2 feedback (3 never driven)
eng_valid_i  in  1  engine result valid
eng_ready_o  out  1  engine result ready
fb_we_o  out  1  load engine D into feedback register this cycle
res_valid_o  out  1  final result valid downstream
res_ready_i  in  1  downstream ready
tile_idx_o  out  KCNT_W  index of the K-step being issued (0..ktiles-1), for operand address generation
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse the cycle after final result handshake
err_o  out  1  one-cycle pulse the cycle after a ktiles==0 command is accepted

Behaviour:
- Reset (async, rst_ni low): state=IDLE, remaining=0, first=0, tile_idx_o=0, done_o=0, err_o=0. All combinational outputs follow IDLE decode: cmd_ready_o=1, eng_ready_o=1, everything else 0.
- Fire on a channel = valid & ready in the same cycle.
- Serialized: at most one engine transaction in flight; each step waits for the prior D (true data dependency through C).
- IDLE:
  - cmd_ready_o=1, eng_ready_o=1, fb_we_o=0. Stale engine results (e.g. after reset mid-job) are drained and dropped.
  - Cmd fire with ktiles==0: err_o pulses next cycle; stay IDLE.
  - Cmd fire with ktiles>0: remaining<=ktiles, first<=1, bias_q<=cmd_bias_i, tile_idx_o<=0; go ISSUE.
- ISSUE:
  - eng_valid_o=op_valid_i, op_ready_o=eng_ready_i (combinational pass-through, no added latency).
  - c_sel_o = first ? {0,bias_q} : 2.
  - On fire: remaining<=remaining-1, first<=0; go WAIT.
  - No valid drop requirement upstream. eng_valid_o must not be asserted outside ISSUE.
- WAIT, remaining!=0 (intermediate):
  - eng_ready_o=1, fb_we_o=eng_valid_i, res_valid_o=0.
  - On eng_valid_i: tile_idx_o<=tile_idx_o+1; go ISSUE.
- WAIT, remaining==0 (last):
  - res_valid_o=eng_valid_i, eng_ready_o=res_ready_i, fb_we_o=0.
  - On result fire: go IDLE, done_o pulses next cycle.
  - Backpressure from res_ready_i holds the engine output.
- c_sel_o holds its ISSUE value through WAIT (the engine samples C at input fire, but the value is kept stable for pipeline debug).
- Simultaneous events:
  - Result fire and a new cmd_valid in the same cycle: cmd is not accepted until the next cycle (cmd_ready_o is only high in IDLE). Min job-to-job gap is 1 cycle.
- Counters: ktiles=2^KCNT_W-1 must complete without wrap; tile_idx_o never exceeds ktiles-1.
- Reset mid-operation: immediate return to IDLE. The external feedback register is not cleared (the next job's first step never selects feedback).

Test Plan:
- ktiles=1, bias=1, op/eng/res always ready, engine latency 3 -> one eng fire with c_sel=1, fb_we never high, res_valid after 3 cycles, done_o pulse next cycle, busy_o low after.
- ktiles=4, bias=0 -> 4 eng fires with c_sel 0,2,2,2; tile_idx_o 0,1,2,3; fb_we_o exactly 3 pulses; exactly one res fire.
- ktiles=3, op_valid_i low for 5 cycles at step 1, res_ready_i low 4 cycles at end -> no eng_valid_o while op_valid low; eng_ready_o low while res_ready low; final result held, single done.
- cmd ktiles=0 -> err_o one pulse, no eng_valid_o, busy_o stays 0; next cmd ktiles=2 is accepted normally.
- ktiles=5, assert rst_ni low during WAIT at step 2, engine returns that result 2 cycles after release -> result drained in IDLE with no fb_we/res_valid; following job ktiles=1 behaves as scenario 1.
- Back-to-back cmds ktiles=2 then 2 with cmd_valid held -> second accepted exactly 1 cycle after first job's result fire; 2 res fires total, 2 done pulses.
